countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_pkg.sv | 34 +++
 rtl/bcd_down_digit.sv | 37 +++
 rtl/countdown_timer.sv | 117 +++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: digit width, BCD limits,
// controller state encoding, count layout and a digit clamp helper.
package countdown_timer_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DEC_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] SEX_MAX = 4'd5;

    // Controller states, kept as plain constants for legacy tool flows.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Count layout M:TS.t, one BCD digit per field.
    typedef struct packed {
        logic [DIGIT_W-1:0] minutes;
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] secs;
        logic [DIGIT_W-1:0] tenths;
    } count_t;

    localparam count_t ZERO_COUNT = '0;

    // Saturate a raw load digit to the largest legal value of its position.
    function automatic logic [DIGIT_W-1:0] clamp_digit(
        input logic [DIGIT_W-1:0] value,
        input logic [DIGIT_W-1:0] limit
    );
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit. Steps when both the chain enable and the
// borrow from the next lower digit are high; wraps 0 -> modulus and
// raises borrow_out on that wrap.
module bcd_down_digit
    import countdown_timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] modulus = DEC_MAX
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               ce,
    input  logic               load,
    input  logic               borrow_in,
    input  logic [DIGIT_W-1:0] load_value,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out
);

    logic step;

    assign step       = ce & borrow_in;
    assign borrow_out = step && (digit == '0);

    // Digit register: load wins over stepping; stepping wraps at zero.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_value;
        end else if (step) begin
            digit <= (digit == '0) ? modulus : digit - 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer M:SS.t driven by a 10 Hz tick. Holds the run/pause/expire
// controller and the load clamp; the count itself is four chained BCD digits.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int MAX_MIN = 5
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               tick,
    input  logic               load,
    input  logic               start_stop,
    input  logic [DIGIT_W-1:0] ld_min,
    input  logic [DIGIT_W-1:0] ld_tens,
    input  logic [DIGIT_W-1:0] ld_secs,
    input  logic [DIGIT_W-1:0] ld_tenths,
    output logic [DIGIT_W-1:0] minutes_digit,
    output logic [DIGIT_W-1:0] tens_seconds_digit,
    output logic [DIGIT_W-1:0] seconds_digit,
    output logic [DIGIT_W-1:0] tenths_digit,
    output logic               running,
    output logic               expired,
    output logic               done
);

    localparam logic [DIGIT_W-1:0] MAX_MIN_D = DIGIT_W'(MAX_MIN);

    logic [1:0] state;
    logic [1:0] state_next;
    count_t     load_count;
    logic       count_zero;
    logic       count_one;
    logic       dec_en;
    logic       expire_now;
    logic       borrow_tenths;
    logic       borrow_secs;
    logic       borrow_tens;
    logic       borrow_min;

    assign count_zero = (minutes_digit == '0) && (tens_seconds_digit == '0) &&
                        (seconds_digit == '0) && (tenths_digit == '0);
    assign count_one  = (minutes_digit == '0) && (tens_seconds_digit == '0) &&
                        (seconds_digit == '0) && (tenths_digit == 4'd1);

    // A tick only moves the count while running; a load in the same cycle wins.
    assign dec_en     = (state == ST_RUN) && tick && !load && !count_zero;
    // Expiry on the last tenth; a minutes borrow would be an underflow and
    // is treated as expiry too so the timer can never run past zero.
    assign expire_now = dec_en && (count_one || borrow_min);

    assign running = (state == ST_RUN);
    assign expired = (state == ST_DONE);

    // Load clamp: out-of-range minutes force the maximum time, other digits saturate.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        load_count = ZERO_COUNT;
        if (ld_min >= MAX_MIN_D) begin
            load_count.minutes = MAX_MIN_D;
        end else begin
            load_count.minutes = ld_min;
            load_count.tens    = clamp_digit(ld_tens, SEX_MAX);
            load_count.secs    = clamp_digit(ld_secs, DEC_MAX);
            load_count.tenths  = clamp_digit(ld_tenths, DEC_MAX);
        end
    end

    bcd_down_digit #(.modulus(DEC_MAX)) u_tenths (
        .CLK(CLK), .reset(reset), .ce(dec_en), .load(load), .borrow_in(1'b1),
        .load_value(load_count.tenths), .digit(tenths_digit), .borrow_out(borrow_tenths)
    );

    bcd_down_digit #(.modulus(DEC_MAX)) u_secs (
        .CLK(CLK), .reset(reset), .ce(dec_en), .load(load), .borrow_in(borrow_tenths),
        .load_value(load_count.secs), .digit(seconds_digit), .borrow_out(borrow_secs)
    );

    bcd_down_digit #(.modulus(SEX_MAX)) u_tens (
        .CLK(CLK), .reset(reset), .ce(dec_en), .load(load), .borrow_in(borrow_secs),
        .load_value(load_count.tens), .digit(tens_seconds_digit), .borrow_out(borrow_tens)
    );

    bcd_down_digit #(.modulus(DEC_MAX)) u_min (
        .CLK(CLK), .reset(reset), .ce(dec_en), .load(load), .borrow_in(borrow_tens),
        .load_value(load_count.minutes), .digit(minutes_digit), .borrow_out(borrow_min)
    );

    // Controller next state: load dominates, expiry dominates pause.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_stop && !count_zero) state_next = ST_RUN;
                ST_RUN: begin
                    if (expire_now)      state_next = ST_DONE;
                    else if (start_stop) state_next = ST_PAUSE;
                end
                ST_PAUSE: if (start_stop) state_next = ST_RUN;
                default:  state_next = ST_DONE;
            endcase
        end
    end

    // State register and the one-cycle done pulse on entry to DONE.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= expire_now;
        end
    end

endmodule
